// File: rtl/kuznechik_encoder_inst.sv
// Kuznechik (GOST R 34.12-2015) single-block encryptor, fully unrolled and combinational.
// Key schedule, nine LSX rounds and the final whitening; clk/rst carry no datapath state.
`timescale 1ns/1ps

module kuznechik_encoder_inst (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] block,
  input  logic [255:0] key,
  output logic [127:0] encoded
);

  localparam int unsigned BLK_W      = 128;
  localparam int unsigned NUM_BYTES  = 16;
  localparam int unsigned NUM_RK     = 10;
  localparam int unsigned NUM_ROUNDS = 9;
  localparam int unsigned NUM_C      = 32;
  localparam int unsigned FEIST_PER  = 8;

  // pi substitution table, pi[0] in the top byte
  localparam logic [2047:0] PI_TABLE = {
    128'hfceedd11cf6e3116fbc4fada23c5044d,
    128'he977f0db932e99ba1736f1bb14cd5fc1,
    128'hf918655ae25cef21811c3c428b018e4f,
    128'h058402aee36a8fa0060bed987fd4d31f,
    128'heb342c51eac848abf22a68a2fd3acecc,
    128'hb5700e56080c7612bf7213479cb75d87,
    128'h15a19629107b9ac7f391786f9d9eb2b1,
    128'h3275193dff358a7e6d54c680c3bd0d57,
    128'hdff524a93ea843c9d779d6f67c22b903,
    128'he00fecde7a94b0bcdce828504e330a4a,
    128'ha79760731e0062441ab83882649f2641,
    128'had454692275e552f8ca3a57d69d5953b,
    128'h0758b34086ac1df730376be488d9e789,
    128'he11b83494c3ff8fe8d53aa90cad88561,
    128'h207167a42d2b095bcb9b25d0bee56c52,
    128'h59a674d2e6f4b4c0d166afc2394b63b6
  };

  // l() coefficients laid out like the operand: byte i multiplies a_i
  localparam logic [127:0] L_COEF = 128'h94_20_85_10_C2_C0_01_FB_01_C0_C2_10_85_20_94_01;

  // pi lookup: entry v sits at bit offset 8*(255-v) = {~v, 3'b000}
  function automatic logic [7:0] pi_sbox(input logic [7:0] v);
    logic [10:0] idx;
    idx = {~v, 3'b000};
    return PI_TABLE[idx +: 8];
  endfunction

  // GF(2^8) multiply: carry-less product, then fold the high bits with 0x1C3
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ (15'(a) << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if (p[i]) p = p ^ (15'(9'h1C3) << (i - 8));
    end
    return p[7:0];
  endfunction

  // linear combination l(a15..a0)
  function automatic logic [7:0] l_func(input logic [127:0] a);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      acc = acc ^ gf_mul(a[8*i +: 8], L_COEF[8*i +: 8]);
    end
    return acc;
  endfunction

  // L = sixteen R steps, each inserting l() as the new top byte
  function automatic logic [127:0] l_layer(input logic [127:0] a);
    logic [127:0] s;
    s = a;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      s = {l_func(s), s[127:8]};
    end
    return s;
  endfunction

  // S: bytewise pi substitution
  function automatic logic [127:0] s_layer(input logic [127:0] a);
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      s[8*i +: 8] = pi_sbox(a[8*i +: 8]);
    end
    return s;
  endfunction

  // round constants C_i = L(Vec128(i)), folded at elaboration
  function automatic logic [NUM_C*BLK_W-1:0] gen_rc();
    logic [NUM_C*BLK_W-1:0] rc;
    rc = '0;
    for (int i = 0; i < int'(NUM_C); i++) begin
      rc[BLK_W*i +: BLK_W] = l_layer(128'(i + 1));
    end
    return rc;
  endfunction

  localparam logic [NUM_C*BLK_W-1:0] RC_ALL = gen_rc();

  logic [BLK_W-1:0] rk [NUM_RK];
  logic [BLK_W-1:0] fa1;
  logic [BLK_W-1:0] fa0;
  logic [BLK_W-1:0] ft;
  logic [BLK_W-1:0] st;

  // clk and rst are interface-only; folded here so they read as consumed
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst};

  // key schedule: K1, K2 from the master key, then four groups of eight Feistel steps
  always_comb begin
    for (int r = 0; r < int'(NUM_RK); r++) rk[r] = '0;
    fa1 = key[255:128];
    fa0 = key[127:0];
    ft  = '0;
    rk[0] = fa1;
    rk[1] = fa0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < int'(FEIST_PER); i++) begin
        ft  = l_layer(s_layer(fa1 ^ RC_ALL[BLK_W*(8*j + i) +: BLK_W])) ^ fa0;
        fa0 = fa1;
        fa1 = ft;
      end
      rk[2*j + 2] = fa1;
      rk[2*j + 3] = fa0;
    end
  end

  // nine LSX rounds and the closing key whitening
  always_comb begin
    st = block;
    for (int r = 0; r < int'(NUM_ROUNDS); r++) begin
      st = l_layer(s_layer(st ^ rk[r]));
    end
    encoded = st ^ rk[NUM_RK-1];
  end

endmodule

// File: tb/tb_kuznechik_encoder_inst.sv
// Self-checking bench for kuznechik_encoder_inst: standard vectors, reset independence,
// same-cycle tracking and a randomized scoreboard against a table-driven reference model.
`timescale 1ns/1ps

module tb_kuznechik_encoder_inst;

  logic         clk;
  logic         rst;
  logic [127:0] block;
  logic [255:0] key;
  logic [127:0] encoded;

  kuznechik_encoder_inst dut (
    .clk     (clk),
    .rst     (rst),
    .block   (block),
    .key     (key),
    .encoded (encoded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] STD_B = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [255:0] STD_K =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] STD_E = 128'h7f679d90bebc24305a468d42b9d4edcd;

  localparam logic [2047:0] PI_HEX = {
    128'hfceedd11cf6e3116fbc4fada23c5044d, 128'he977f0db932e99ba1736f1bb14cd5fc1,
    128'hf918655ae25cef21811c3c428b018e4f, 128'h058402aee36a8fa0060bed987fd4d31f,
    128'heb342c51eac848abf22a68a2fd3acecc, 128'hb5700e56080c7612bf7213479cb75d87,
    128'h15a19629107b9ac7f391786f9d9eb2b1, 128'h3275193dff358a7e6d54c680c3bd0d57,
    128'hdff524a93ea843c9d779d6f67c22b903, 128'he00fecde7a94b0bcdce828504e330a4a,
    128'ha79760731e0062441ab83882649f2641, 128'had454692275e552f8ca3a57d69d5953b,
    128'h0758b34086ac1df730376be488d9e789, 128'he11b83494c3ff8fe8d53aa90cad88561,
    128'h207167a42d2b095bcb9b25d0bee56c52, 128'h59a674d2e6f4b4c0d166afc2394b63b6
  };

  // coefficient of byte a_i in l(), indexed from a0 upward
  localparam int LCOEF [16] = '{1, 148, 32, 133, 16, 194, 192, 1,
                                251, 1, 192, 194, 16, 133, 32, 148};

  int unsigned  n_checks;
  int unsigned  n_fail;
  logic [127:0] exp_q [$];
  logic [7:0]   pi_rom [256];
  logic [7:0]   mul_tab [16][256];
  logic [127:0] rc [1:32];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // shift-and-reduce multiply, reducing by 0xC3 as each x^8 term appears
  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [127:0] model_s(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = pi_rom[a[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] model_r(input logic [127:0] a);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 16; i++) x = x ^ mul_tab[i][a[8*i +: 8]];
    return {x, a[127:8]};
  endfunction

  function automatic logic [127:0] model_l(input logic [127:0] a);
    logic [127:0] s;
    s = a;
    for (int i = 0; i < 16; i++) s = model_r(s);
    return s;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] b, input logic [255:0] k);
    logic [127:0] ks [10];
    logic [127:0] x;
    logic [127:0] y;
    logic [127:0] t;
    ks[0] = k[255:128];
    ks[1] = k[127:0];
    x = ks[0];
    y = ks[1];
    for (int n = 1; n <= 32; n++) begin
      t = model_l(model_s(x ^ rc[n])) ^ y;
      y = x;
      x = t;
      if (n % 8 == 0) begin
        ks[n/4]     = x;
        ks[n/4 + 1] = y;
      end
    end
    t = b;
    for (int r = 0; r < 9; r++) t = model_l(model_s(t ^ ks[r]));
    return t ^ ks[9];
  endfunction

  task automatic drive(input logic [127:0] b, input logic [255:0] k, input logic [127:0] e);
    @(negedge clk);
    block = b;
    key   = k;
    exp_q.push_back(e);
  endtask

  task automatic collect(input string tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", tag, encoded);
    end else begin
      check_eq(tag, encoded, exp_q.pop_front());
    end
  endtask

  task automatic check_now(input string tag);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", tag, encoded);
    end else begin
      check_eq(tag, encoded, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [127:0] rb1;
    logic [127:0] rb2;
    logic [127:0] rbl;
    logic [255:0] rk;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b0;
    block = '0;
    key   = '0;

    for (int v = 0; v < 256; v++) pi_rom[v] = PI_HEX[2047 - 8*v -: 8];
    for (int i = 0; i < 16; i++)
      for (int v = 0; v < 256; v++) mul_tab[i][v] = tb_gmul(8'(LCOEF[i]), 8'(v));
    for (int n = 1; n <= 32; n++) rc[n] = model_l(128'(n));

    // reference model against the published layer vectors
    check_eq("model_S", model_s(128'hffeeddccbbaa99881122334455667700),
             128'hb66cd8887d38e8d77765aeea0c9a7efc);
    check_eq("model_R", model_r(128'h00000000000000000000000000000100),
             128'h94000000000000000000000000000001);
    check_eq("model_L", model_l(128'h64a59400000000000000000000000000),
             128'hd456584dd0e3e84cc3166e4b7fa2890d);
    check_eq("model_C1", rc[1], 128'h6ea276726c487ab85d27bd10dd849401);
    check_eq("model_X_K1", STD_B ^ STD_K[255:128], 128'h99bb99ff99bb99ffffffffffffffffff);
    check_eq("model_std", model_encrypt(STD_B, STD_K), STD_E);

    // standard vector while rst is held low from time zero
    drive(STD_B, STD_K, STD_E);
    collect("std_rst_low");
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(STD_E);
    collect("std_rst_high");

    // reset asserted, held, toggled and pulsed mid-cycle
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(STD_E);
    check_now("rst_assert");
    exp_q.push_back(STD_E);
    collect("rst_hold_1");
    exp_q.push_back(STD_E);
    collect("rst_hold_2");
    for (int i = 0; i < 4; i++) begin
      #3 rst = ~rst;
      exp_q.push_back(STD_E);
      check_now("rst_toggle");
    end
    @(posedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    exp_q.push_back(STD_E);
    check_now("rst_pulse_low");
    #1 rst = 1'b1;
    exp_q.push_back(STD_E);
    check_now("rst_pulse_high");
    exp_q.push_back(STD_E);
    collect("rst_after_pulse");

    // extreme operands
    drive('0, '0, model_encrypt('0, '0));
    collect("all_zero");
    drive('1, '1, model_encrypt('1, '1));
    collect("all_one");
    drive(STD_B, '0, model_encrypt(STD_B, '0));
    collect("std_blk_zero_key");
    drive('0, STD_K, model_encrypt('0, STD_K));
    collect("zero_blk_std_key");

    // two block values between clock edges; output follows each
    rb1 = {$urandom, $urandom, $urandom, $urandom};
    rb2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    key   = STD_K;
    block = rb1;
    exp_q.push_back(model_encrypt(rb1, STD_K));
    check_now("same_cycle_a");
    block = rb2;
    exp_q.push_back(model_encrypt(rb2, STD_K));
    check_now("same_cycle_b");
    block = rb1;
    exp_q.push_back(model_encrypt(rb1, STD_K));
    check_now("same_cycle_c");

    // randomized scoreboard
    for (int n = 0; n < 1000; n++) begin
      rbl = {$urandom, $urandom, $urandom, $urandom};
      rk  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drive(rbl, rk, model_encrypt(rbl, rk));
      collect("random");
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
